// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the pipeline controller and the RV32M multiply/divide unit.
interface rv32m_muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_data, rs2_data,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data,
        output busy, done, result
    );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Macro MULDIV_DIV_EN builds the divide datapath; without it divide ops return 0 after 2 cycles.
module rv32m_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    rv32m_muldiv_unit_if.slave bus
);
    localparam int unsigned     PW        = 2 * XLEN;
    localparam int unsigned     CNTW      = 6;
    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(XLEN - 1);
`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] opd_q;
    logic [PW-1:0]   prod_q;
    logic            neg_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            special;
    logic [XLEN-1:0] opd_d;
    logic [PW-1:0]   prod_ld;
    logic            neg_d;
    logic [XLEN:0]   mul_sum;
    logic [PW-1:0]   prod_d;
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] result_d;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_trial;
`endif

    // Operand decode: signedness, magnitudes and the load image for an accepted request
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase

        a_neg   = a_signed & bus.rs1_data[XLEN-1];
        b_neg   = b_signed & bus.rs2_data[XLEN-1];
        a_mag   = a_neg ? -bus.rs1_data : bus.rs1_data;
        b_mag   = b_neg ? -bus.rs2_data : bus.rs2_data;

        // Multiply keeps the multiplier in the low half; divide keeps the dividend there
        opd_d   = bus.funct3[2] ? b_mag : a_mag;
        prod_ld = {{XLEN{1'b0}}, (bus.funct3[2] ? a_mag : b_mag)};
        neg_d   = (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
        special = 1'b0;

`ifdef MULDIV_DIV_EN
        // Special results are preloaded so FIX picks them from the right half unchanged
        if (bus.funct3[2]) begin
            if (bus.rs2_data == '0) begin
                special = 1'b1;
                prod_ld = {bus.rs1_data, ALL_ONES};
                neg_d   = 1'b0;
            end else if (!bus.funct3[0] && bus.rs1_data == MIN_INT && bus.rs2_data == ALL_ONES) begin
                special = 1'b1;
                prod_ld = {{XLEN{1'b0}}, MIN_INT};
                neg_d   = 1'b0;
            end
        end
`else
        if (bus.funct3[2]) begin
            special = 1'b1;
            prod_ld = '0;
            neg_d   = 1'b0;
        end
`endif
    end

    // One iteration: high half accumulates (multiply) or holds the partial remainder (divide)
    always_comb begin
        mul_sum = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, opd_q} : '0);
        prod_d  = {mul_sum, prod_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opd_q};
        if (funct3_q[2]) begin
            if (div_trial[XLEN+1]) begin
                prod_d = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
            end else begin
                prod_d = {XLEN'(div_trial), prod_q[XLEN-2:0], 1'b1};
            end
        end
`endif
    end

    // Sign fix-up and word select; the low half of the negated 64-bit value is the negated quotient
    always_comb begin
        prod_fix = neg_q ? -prod_q : prod_q;
        case (funct3_q)
            3'b000, 3'b100, 3'b101: result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[PW-1:XLEN];
            default:                result_d = neg_q ? -prod_q[PW-1:XLEN] : prod_q[PW-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            opd_q    <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        funct3_q <= bus.funct3;
                        opd_q    <= opd_d;
                        prod_q   <= prod_ld;
                        neg_q    <= neg_d;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= special ? FIX : CALC;
                    end
                end
                CALC: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + CNTW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: doc/rv32m_muldiv_unit.md
# rv32m_muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file. It consumes the two read-port operands (RD1/RD2 values) and the instruction's funct3 field. It computes the M-extension result over multiple cycles and presents it for the writeback path. The controller stalls the PC and holds operands steady while `busy` is high, and commits `result` to the register file on the `done` pulse.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when `busy`=0.
- `funct3` input 3: operation, sampled with `start`.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data` input 32: operand A (multiplicand/dividend), sampled with `start`.
- `rs2_data` input 32: operand B (multiplier/divisor), sampled with `start`.
- `busy` output 1: operation in progress; new `start` ignored.
- `done` output 1: one-cycle pulse; `result` valid.
- `result` output 32: final result, held until the next accepted `start` or `rst`.

## Operation
- FSM states IDLE, CALC, FIX.
- IDLE: on `start`, latch `funct3`, operand magnitudes and sign flags, and clear the 6-bit iteration counter.
  - Special case detected: go to FIX.
  - Otherwise: go to CALC.
  - Set `busy`=1.
- CALC, multiply: radix-2 shift-add on unsigned magnitudes into a 64-bit product, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle, 32-bit remainder plus 33-bit trial subtract.
- CALC: counter increments each cycle; after the 32nd CALC cycle, go to FIX.
- FIX: apply signs, select the output word, load `result`, pulse `done`, clear `busy`, go to IDLE.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Negative magnitudes are two's-complement, mod 2^32 (0x80000000 stays 0x80000000 as an unsigned magnitude).
- Product sign: negate the 64-bit product if the operand signs differ (signed operands only).
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Quotient sign: negative if the operand signs differ. Remainder sign: follows the dividend.
- Special cases (no CALC phase):
  - Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result `rs1_data`.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000; REM result 0.
- `start` while `busy`=1 is ignored, with no effect on the in-flight operation.
- Operand inputs are don't-care after the `start` sampling edge.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
- `rst` mid-operation aborts; outputs reach reset values after that edge, and no `done` is emitted.
- Let edge E0 be the edge that accepts `start`. `busy` is high from after E0.
- Normal latency:
  - CALC occupies E1..E32.
  - FIX at E33: `result` updates, `done`=1 and `busy`=0 for the cycle after E33.
  - Total 34 cycles from `start` to `done`.
- Special-case latency: FIX at E1; `done` is high for the cycle after E1 (2 cycles).
- `done` is high for exactly one cycle.
- `start` may be asserted in the same cycle as `done`, since `busy`=0; it is accepted at that edge, with no idle bubble required.
- Back-to-back operations: `done` pulses are 34 cycles apart.
- `rst` takes priority over `start` on the same edge.

## Configuration
- Macro `MULDIV_DIV_EN`.
- Defined: full RV32M, with divide datapath, divide special cases and restoring-division logic.
- Undefined: divide hardware is omitted.
  - funct3[2]=1 takes the special-case path: `result`=0, `done` after the 2-cycle latency.
  - Multiply operation is unchanged.

## Test plan
- Reset: `rst`=1 for 2 cycles with `start`=1 → `busy`=0, `done`=0, `result`=0.
- MUL and MULH, A=0xFFFFFFFE (-2), B=0x00000003:
  - MUL → 0xFFFFFFFA with `done` 34 cycles after `start`.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000002.
- DIV and REM, A=0xFFFFFFF9 (-7), B=0x00000002:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 0x00000001.
- Special cases, each with `done` 2 cycles after `start`:
  - DIV by 0 with A=0x12345678 → 0xFFFFFFFF.
  - REMU by 0 → 0x12345678.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Handshake:
  - Pulse `start` at cycle 10 of an active MUL → ignored; original result intact.
  - Assert `start` on the `done` cycle → accepted; next `done` 34 cycles later.
- Abort: `rst` at cycle 15 of a DIVU → `busy` low next cycle, no `done`, `result`=0.
- With `MULDIV_DIV_EN` undefined: DIVU 100/7 → `result`=0 after 2 cycles.
